// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - HD44780 constants, ASCII codes, FSM state types and digit helper
package lcd_pkg;

    localparam logic [7:0] FUNC_SET_4B = 8'h28;
    localparam logic [7:0] ENTRY_INC   = 8'h06;
    localparam logic [7:0] DISP_ON     = 8'h0C;
    localparam logic [7:0] CLEAR       = 8'h01;
    localparam logic [7:0] DDRAM_L1    = 8'h80;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        CFG,
        SNAP,
        ADDR,
        CHARS,
        FRAME_WAIT
    } lcd_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_HOLD,
        TX_POST
    } tx_phase_t;

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One ASCII digit of a 0..63 value; an out-of-range field renders as a dash.
    function automatic logic [7:0] digit_char(input logic [5:0] v, input logic tens, input logic valid);
        logic [5:0] d;
        d = tens ? (v / 6'd10) : (v % 6'd10);
        return valid ? (ASCII_0 + {2'b00, d}) : ASCII_DASH;
    endfunction

endpackage

// File: rtl/lcd_time_display_if.sv
// rtl/lcd_time_display_if.sv - character LCD 4-bit write bus
interface lcd_time_display_if;
    logic [3:0] SF_D;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       SF_CE0;

    modport master (output SF_D, LCD_E, LCD_RS, LCD_RW, SF_CE0);
    modport slave  (input  SF_D, LCD_E, LCD_RS, LCD_RW, SF_CE0);
endinterface

// File: rtl/lcd_nibble_tx.sv
// rtl/lcd_nibble_tx.sv - one LCD nibble write: setup, enable pulse, hold, post-delay
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int unsigned TW      = 8,
    parameter int unsigned E_SETUP = 2,
    parameter int unsigned E_PULSE = 12,
    parameter int unsigned E_HOLD  = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic [3:0]    nibble,
    input  logic          rs,
    input  logic [TW-1:0] post_delay,
    output logic          busy,
    output logic          done,
    output logic [3:0]    sf_d,
    output logic          lcd_e,
    output logic          lcd_rs
);

    tx_phase_t     phase, phase_nxt;
    logic [TW-1:0] tmr;
    logic [TW-1:0] post_q;
    logic          tmr_zero;

    assign tmr_zero = (tmr == '0);

    // Bus data only loads in idle, so it can never move while lcd_e is high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase  <= TX_IDLE;
            tmr    <= '0;
            post_q <= '0;
            sf_d   <= 4'h0;
            lcd_rs <= 1'b0;
            lcd_e  <= 1'b0;
        end else begin
            phase <= phase_nxt;
            lcd_e <= (phase_nxt == TX_PULSE);
            if (phase == TX_IDLE && start) begin
                sf_d   <= nibble;
                lcd_rs <= rs;
                post_q <= post_delay;
            end
            if (phase_nxt != phase) begin
                case (phase_nxt)
                    TX_SETUP: tmr <= TW'(E_SETUP - 1);
                    TX_PULSE: tmr <= TW'(E_PULSE - 1);
                    TX_HOLD:  tmr <= TW'(E_HOLD - 1);
                    TX_POST:  tmr <= post_q - 1'b1;
                    default:  tmr <= '0;
                endcase
            end else if (!tmr_zero) begin
                tmr <= tmr - 1'b1;
            end
        end
    end

    always_comb begin
        phase_nxt = phase;
        case (phase)
            TX_IDLE:  if (start)    phase_nxt = TX_SETUP;
            TX_SETUP: if (tmr_zero) phase_nxt = TX_PULSE;
            TX_PULSE: if (tmr_zero) phase_nxt = TX_HOLD;
            TX_HOLD:  if (tmr_zero) phase_nxt = TX_POST;
            TX_POST:  if (tmr_zero) phase_nxt = TX_IDLE;
            default:                phase_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        busy = (phase != TX_IDLE);
        done = (phase == TX_POST) && tmr_zero;
    end

endmodule

// File: rtl/lcd_time_display.sv
// rtl/lcd_time_display.sv - HH:MM:SS on HD44780 line 1: power-on init then endless refresh
module lcd_time_display
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_INIT1 = 205000,
    parameter int unsigned T_INIT2 = 5000,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLEAR = 82000,
    parameter int unsigned T_NIB   = 50,
    parameter int unsigned E_SETUP = 2,
    parameter int unsigned E_PULSE = 12,
    parameter int unsigned E_HOLD  = 1,
    parameter int unsigned T_FRAME = 500000
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [5:0]         sec_digits,
    input  logic [5:0]         min_digits,
    input  logic [4:0]         hrs_digits,
    lcd_time_display_if.master lcd,
    output logic               init_done
);

    localparam int unsigned MAX_D = max_of(
        max_of(max_of(T_PWRUP, T_INIT1), max_of(T_INIT2, T_CMD)),
        max_of(max_of(T_CLEAR, T_NIB), max_of(T_FRAME, max_of(E_SETUP, max_of(E_PULSE, E_HOLD)))));
    localparam int TW = $clog2(MAX_D + 1);

    lcd_state_t    state, state_nxt;
    logic          wait_ld;
    logic [TW-1:0] wait_tmr;
    logic          wait_exp;
    logic [2:0]    idx;
    logic          lo;
    logic [4:0]    snap_h;
    logic [5:0]    snap_m, snap_s;
    logic [7:0]    byte_v, char_v;

    logic          tx_start, tx_rs, tx_busy, tx_done;
    logic [3:0]    tx_nib, tx_sf_d;
    logic          tx_e, tx_lcd_rs;
    logic [TW-1:0] tx_post;

    lcd_nibble_tx #(
        .TW      (TW),
        .E_SETUP (E_SETUP),
        .E_PULSE (E_PULSE),
        .E_HOLD  (E_HOLD)
    ) u_tx (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (tx_start),
        .nibble     (tx_nib),
        .rs         (tx_rs),
        .post_delay (tx_post),
        .busy       (tx_busy),
        .done       (tx_done),
        .sf_d       (tx_sf_d),
        .lcd_e      (tx_e),
        .lcd_rs     (tx_lcd_rs)
    );

    assign lcd.SF_D   = tx_sf_d;
    assign lcd.LCD_E  = tx_e;
    assign lcd.LCD_RS = tx_lcd_rs;
    assign lcd.LCD_RW = 1'b0;
    assign lcd.SF_CE0 = 1'b1;

    assign wait_exp = !wait_ld && (wait_tmr == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= PWR_WAIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PWR_WAIT:   if (wait_exp)                        state_nxt = INIT;
            INIT:       if (tx_done && idx == 3'd3)          state_nxt = CFG;
            CFG:        if (tx_done && lo && idx == 3'd3)    state_nxt = SNAP;
            SNAP:                                            state_nxt = ADDR;
            ADDR:       if (tx_done && lo)                   state_nxt = CHARS;
            CHARS:      if (tx_done && lo && idx == 3'd7)    state_nxt = FRAME_WAIT;
            FRAME_WAIT: if (wait_exp)                        state_nxt = SNAP;
            default:                                         state_nxt = PWR_WAIT;
        endcase
    end

    // wait_ld gives every state one cycle to load its wait, so reset can leave the timer at zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_ld   <= 1'b1;
            wait_tmr  <= '0;
            idx       <= 3'd0;
            lo        <= 1'b0;
            snap_h    <= 5'd0;
            snap_m    <= 6'd0;
            snap_s    <= 6'd0;
            init_done <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                wait_ld <= 1'b1;
                idx     <= 3'd0;
                lo      <= 1'b0;
            end else begin
                if (wait_ld) begin
                    wait_ld  <= 1'b0;
                    wait_tmr <= (state == FRAME_WAIT) ? TW'(T_FRAME - 1) : TW'(T_PWRUP - 1);
                end else if (wait_tmr != '0) begin
                    wait_tmr <= wait_tmr - 1'b1;
                end
                if (tx_done) begin
                    if (state == INIT || lo) begin
                        idx <= idx + 3'd1;
                        lo  <= 1'b0;
                    end else begin
                        lo  <= 1'b1;
                    end
                end
            end
            if (state == SNAP) begin
                snap_h <= hrs_digits;
                snap_m <= min_digits;
                snap_s <= sec_digits;
            end
            if (state == CFG && state_nxt == SNAP) init_done <= 1'b1;
        end
    end

    always_comb begin
        char_v = ASCII_COLON;
        case (idx)
            3'd0:    char_v = digit_char({1'b0, snap_h}, 1'b1, snap_h <= 5'd23);
            3'd1:    char_v = digit_char({1'b0, snap_h}, 1'b0, snap_h <= 5'd23);
            3'd3:    char_v = digit_char(snap_m, 1'b1, snap_m <= 6'd59);
            3'd4:    char_v = digit_char(snap_m, 1'b0, snap_m <= 6'd59);
            3'd6:    char_v = digit_char(snap_s, 1'b1, snap_s <= 6'd59);
            3'd7:    char_v = digit_char(snap_s, 1'b0, snap_s <= 6'd59);
            default: char_v = ASCII_COLON;
        endcase
    end

    always_comb begin
        tx_start = 1'b0;
        tx_rs    = 1'b0;
        tx_nib   = 4'h0;
        tx_post  = TW'(T_CMD);
        byte_v   = 8'h00;
        case (state)
            INIT: begin
                tx_start = !tx_busy;
                case (idx[1:0])
                    2'd0:    begin tx_nib = 4'h3; tx_post = TW'(T_INIT1); end
                    2'd1:    begin tx_nib = 4'h3; tx_post = TW'(T_INIT2); end
                    2'd2:    begin tx_nib = 4'h3; tx_post = TW'(T_CMD);   end
                    default: begin tx_nib = 4'h2; tx_post = TW'(T_CMD);   end
                endcase
            end
            CFG, ADDR, CHARS: begin
                tx_start = !tx_busy;
                if (state == CFG) begin
                    case (idx[1:0])
                        2'd0:    byte_v = FUNC_SET_4B;
                        2'd1:    byte_v = ENTRY_INC;
                        2'd2:    byte_v = DISP_ON;
                        default: byte_v = CLEAR;
                    endcase
                end else if (state == ADDR) begin
                    byte_v = DDRAM_L1;
                end else begin
                    byte_v = char_v;
                    tx_rs  = 1'b1;
                end
                tx_nib = lo ? byte_v[3:0] : byte_v[7:4];
                if (!lo)                                 tx_post = TW'(T_NIB);
                else if (state == CFG && byte_v == CLEAR) tx_post = TW'(T_CLEAR);
                else                                     tx_post = TW'(T_CMD);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_time_display.sv
// tb/tb_lcd_time_display.sv - scoreboard bench decoding the LCD bus against expected nibbles/bytes
module tb_lcd_time_display;

    localparam int TP = 4;
    localparam int ES = 4;
    localparam int EP = 3;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [5:0] sec_digits = 6'd0;
    logic [5:0] min_digits = 6'd0;
    logic [4:0] hrs_digits = 5'd0;
    logic       init_done;

    lcd_time_display_if lcd_bus();

    lcd_time_display #(
        .T_PWRUP (TP), .T_INIT1 (TP), .T_INIT2 (TP), .T_CMD (TP), .T_CLEAR (TP),
        .T_NIB   (TP), .E_SETUP (ES), .E_PULSE (EP), .E_HOLD (TP), .T_FRAME (TP)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .sec_digits (sec_digits),
        .min_digits (min_digits),
        .hrs_digits (hrs_digits),
        .lcd        (lcd_bus),
        .init_done  (init_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       single;
        logic       rs;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fld(input int v, input int lim, input bit tens);
        if (v > lim) return 8'h2D;
        return 8'(8'h30 + (tens ? v / 10 : v % 10));
    endfunction

    task automatic push_nib(input logic [3:0] n);
        sb.push_back('{single: 1'b1, rs: 1'b0, val: {4'h0, n}});
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] v);
        sb.push_back('{single: 1'b0, rs: rs, val: v});
    endtask

    task automatic push_init();
        push_nib(4'h3); push_nib(4'h3); push_nib(4'h3); push_nib(4'h2);
        push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C); push_byte(1'b0, 8'h01);
    endtask

    task automatic set_push(input int h, input int m, input int s);
        hrs_digits = 5'(h);
        min_digits = 6'(m);
        sec_digits = 6'(s);
        push_byte(1'b0, 8'h80);
        push_byte(1'b1, fld(h, 23, 1'b1)); push_byte(1'b1, fld(h, 23, 1'b0));
        push_byte(1'b1, 8'h3A);
        push_byte(1'b1, fld(m, 59, 1'b1)); push_byte(1'b1, fld(m, 59, 1'b0));
        push_byte(1'b1, 8'h3A);
        push_byte(1'b1, fld(s, 59, 1'b1)); push_byte(1'b1, fld(s, 59, 1'b0));
    endtask

    task automatic wait_q(input int n, input string tag);
        int k;
        k = 0;
        while (sb.size() > n && k < 5000) begin
            @(negedge CLK);
            k++;
        end
        check({tag, "_drain"}, (sb.size() <= n), 1);
    endtask

    // Bus monitor state
    logic       prev_e, prev_rs, hold_rs;
    logic [3:0] prev_d, hold_d;
    int         hi_cnt, stable, nib_cnt, rel_cyc, clr_cnt;
    bit         half, seen_rise, clr_wait;

    task automatic pop_cmp(input bit single, input logic rs, input logic [7:0] v);
        exp_t x;
        if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
            return;
        end
        x = sb.pop_front();
        if (single) check("init_nibble", {single, rs, v}, {x.single, x.rs, x.val});
        else        check("bus_byte",    {single, rs, v}, {x.single, x.rs, x.val});
        if (!single && !rs && v == 8'h01) begin
            check("init_done_early", init_done, 0);
            clr_wait = 1'b1;
            clr_cnt  = 0;
        end
    endtask

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_e = 1'b0; prev_rs = 1'b0; prev_d = 4'h0;
            hi_cnt = 0; stable = 0; nib_cnt = 0; rel_cyc = 0;
            half = 1'b0; seen_rise = 1'b0; clr_wait = 1'b0; clr_cnt = 0;
        end else begin
            rel_cyc++;
            if ({lcd_bus.SF_D, lcd_bus.LCD_RS} != {prev_d, prev_rs}) stable = 1;
            else stable++;
            if (clr_wait) begin
                clr_cnt++;
                if (init_done) begin
                    check("init_done_delay", clr_cnt, TP + TP);
                    clr_wait = 1'b0;
                end else if (clr_cnt > 200) begin
                    check("init_done_rise", init_done, 1);
                    clr_wait = 1'b0;
                end
            end
            if (lcd_bus.LCD_E) begin
                if (!prev_e) begin
                    hi_cnt = 1;
                    check("e_setup", (stable >= ES + 1), 1);
                    if (!seen_rise) begin
                        seen_rise = 1'b1;
                        check("pwrup_wait", (rel_cyc >= TP + ES), 1);
                    end
                end else begin
                    hi_cnt++;
                    check("bus_stable_e_high", {lcd_bus.SF_D, lcd_bus.LCD_RS}, {prev_d, prev_rs});
                end
            end else if (prev_e) begin
                check("e_width", hi_cnt, EP);
                check("rw_ce0", {lcd_bus.LCD_RW, lcd_bus.SF_CE0}, 2'b01);
                if (nib_cnt < 4) begin
                    nib_cnt++;
                    pop_cmp(1'b1, lcd_bus.LCD_RS, {4'h0, lcd_bus.SF_D});
                end else if (!half) begin
                    half    = 1'b1;
                    hold_d  = lcd_bus.SF_D;
                    hold_rs = lcd_bus.LCD_RS;
                end else begin
                    half = 1'b0;
                    check("rs_pair", lcd_bus.LCD_RS, hold_rs);
                    pop_cmp(1'b0, hold_rs, {hold_d, lcd_bus.SF_D});
                end
            end
            prev_e  = lcd_bus.LCD_E;
            prev_d  = lcd_bus.SF_D;
            prev_rs = lcd_bus.LCD_RS;
        end
    end

    initial begin
        int k;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_bus",
              {lcd_bus.SF_D, lcd_bus.LCD_E, lcd_bus.LCD_RS, lcd_bus.LCD_RW, lcd_bus.SF_CE0, init_done},
              {4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

        push_init();
        set_push(13, 5, 59);
        RST_N = 1'b1;
        wait_q(0, "init_frame");
        check("init_done_high", init_done, 1);

        set_push(23, 59, 59);
        wait_q(5, "frame_2359_part");
        set_push(0, 0, 0);
        wait_q(0, "frame_0000");

        set_push(31, 60, 0);
        wait_q(0, "frame_out_of_range");

        set_push(12, 34, 56);
        wait_q(4, "frame_pre_reset");
        k = 0;
        while (!lcd_bus.LCD_E && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check("e_high_before_reset", lcd_bus.LCD_E, 1);
        RST_N = 1'b0;
        #1;
        check("reset_mid_e", lcd_bus.LCD_E, 0);
        check("reset_mid_init_done", init_done, 0);
        sb.delete();
        repeat (3) @(negedge CLK);
        check("reset_mid_bus", {lcd_bus.SF_D, lcd_bus.LCD_RS}, 5'h00);

        push_init();
        set_push(12, 34, 56);
        RST_N = 1'b1;
        wait_q(0, "reinit_frame");
        check("reinit_done_high", init_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
